// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port front end for a single-port word memory.
// Keeps one transaction in flight; partial-strobe writes become read-modify-write.
module dmem_arbiter #(
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [31:0]       i_req0_addr,
  input  logic [31:0]       i_req0_wdata,
  input  logic [3:0]        i_req0_wstrb,
  output logic              o_rsp0_valid,
  output logic [31:0]       o_rsp0_rdata,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [31:0]       i_req1_addr,
  input  logic [31:0]       i_req1_wdata,
  input  logic [3:0]        i_req1_wstrb,
  output logic              o_rsp1_valid,
  output logic [31:0]       o_rsp1_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_we,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR_ACK  = 3'd2,
    RMW     = 3'd3,
    RMW_ACK = 3'd4
  } state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] new_w,
                                              input logic [31:0] old_w,
                                              input logic [3:0]  strb);
    return {strb[3] ? new_w[31:24] : old_w[31:24],
            strb[2] ? new_w[23:16] : old_w[23:16],
            strb[1] ? new_w[15:8]  : old_w[15:8],
            strb[0] ? new_w[7:0]   : old_w[7:0]};
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                last_grant_r;
  logic                port_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [3:0]          wstrb_r;
  logic [31:0]         old_r;

  logic                grant_s;
  logic                accept_s;
  logic [31:0]         sel_addr_s;
  logic [31:0]         sel_wdata_s;
  logic [3:0]          sel_wstrb_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [31:0]         mem_wdata_s;
  logic                mem_we_s;
  logic                rsp_valid_s;
  logic [31:0]         rsp_rdata_s;
  logic                unused_addr_bits_s;

  // Byte offset and bits above the memory size are dropped, so addresses wrap.
  assign unused_addr_bits_s = ^{i_req0_addr[31:ADDR_W+2], i_req0_addr[1:0],
                                i_req1_addr[31:ADDR_W+2], i_req1_addr[1:0]};

  // Round-robin pick: on contention the port that did not win last time goes.
  always_comb begin
    grant_s = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (i_req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s    = (state_r == IDLE) && (i_req0_valid || i_req1_valid);
  assign sel_addr_s  = grant_s ? i_req1_addr  : i_req0_addr;
  assign sel_wdata_s = grant_s ? i_req1_wdata : i_req0_wdata;
  assign sel_wstrb_s = grant_s ? i_req1_wstrb : i_req0_wstrb;

  // Next-state and memory/response drive for the single in-flight transaction.
  always_comb begin
    state_nxt_s = state_r;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = 32'h0;
    mem_we_s    = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = 32'h0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          mem_addr_s = sel_addr_s[ADDR_W+1:2];
          if (sel_wstrb_s == 4'h0) begin
            state_nxt_s = RD;
          end else if (sel_wstrb_s == 4'hF) begin
            mem_wdata_s = sel_wdata_s;
            mem_we_s    = 1'b1;
            state_nxt_s = WR_ACK;
          end else begin
            state_nxt_s = RMW;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        mem_addr_s  = addr_r;
        rsp_valid_s = 1'b1;
        rsp_rdata_s = i_mem_rdata;
        state_nxt_s = IDLE;
      end
      WR_ACK: begin
        mem_addr_s  = addr_r;
        rsp_valid_s = 1'b1;
        state_nxt_s = IDLE;
      end
      RMW: begin
        mem_addr_s  = addr_r;
        mem_wdata_s = merge_bytes(wdata_r, i_mem_rdata, wstrb_r);
        mem_we_s    = 1'b1;
        state_nxt_s = RMW_ACK;
      end
      RMW_ACK: begin
        mem_addr_s  = addr_r;
        rsp_valid_s = 1'b1;
        rsp_rdata_s = old_r;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and round-robin history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        last_grant_r <= grant_s;
      end
    end
  end

  // Payload latched at accept; old word captured while the merged write goes out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      port_r  <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= 32'h0;
      wstrb_r <= 4'h0;
      old_r   <= 32'h0;
    end else begin
      if (accept_s) begin
        port_r  <= grant_s;
        addr_r  <= sel_addr_s[ADDR_W+1:2];
        wdata_r <= sel_wdata_s;
        wstrb_r <= sel_wstrb_s;
      end
      if (state_r == RMW) begin
        old_r <= i_mem_rdata;
      end
    end
  end

  // Reset forces every output low immediately, including a pending RMW write.
  assign o_req0_ready = i_rst_n & accept_s & ~grant_s;
  assign o_req1_ready = i_rst_n & accept_s & grant_s;
  assign o_mem_addr   = i_rst_n ? mem_addr_s : {ADDR_W{1'b0}};
  assign o_mem_wdata  = i_rst_n ? mem_wdata_s : 32'h0;
  assign o_mem_we     = i_rst_n & mem_we_s;
  assign o_rsp0_valid = i_rst_n & rsp_valid_s & ~port_r;
  assign o_rsp1_valid = i_rst_n & rsp_valid_s & port_r;
  assign o_rsp0_rdata = (i_rst_n && rsp_valid_s && !port_r) ? rsp_rdata_s : 32'h0;
  assign o_rsp1_rdata = (i_rst_n && rsp_valid_s && port_r) ? rsp_rdata_s : 32'h0;

endmodule
